// File: rtl/mmss_countdown.sv
// Microwave cooking timer: 4-digit BCD mm:ss entry register with a 1 Hz countdown.
// Ports: clk, clearn (async clear), en, key_valid/key_data in; BCD digits, timer_done, tick out.
module mmss_countdown #(
  parameter int CLK_PER_SEC = 1000000,
  parameter int PS_W        = $clog2(CLK_PER_SEC)
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       en,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       timer_done,
  output logic       tick
);

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_PER_SEC - 1);

  logic [PS_W-1:0] ps;
  logic            last;
  logic            go;
  logic            load;
  logic [3:0]      n_so;
  logic [3:0]      n_st;
  logic [3:0]      n_mo;
  logic [3:0]      n_mt;

  assign timer_done = (sec_ones == 4'd0) && (sec_tens == 4'd0)
                   && (min_ones == 4'd0) && (min_tens == 4'd0);

  assign last = (ps == PS_MAX);
  assign go   = en && !timer_done && last;
  assign load = !en && key_valid && (key_data <= 4'd9);

  // Borrow chain; only used when not done, so min_tens is
  // never decremented from zero.
  always_comb begin
    n_so = sec_ones;
    n_st = sec_tens;
    n_mo = min_ones;
    n_mt = min_tens;
    if (sec_ones != 4'd0) begin
      n_so = sec_ones - 4'd1;
    end else if (sec_tens != 4'd0) begin
      n_st = sec_tens - 4'd1;
      n_so = 4'd9;
    end else if (min_ones != 4'd0) begin
      n_mo = min_ones - 4'd1;
      n_st = 4'd5;
      n_so = 4'd9;
    end else begin
      n_mt = min_tens - 4'd1;
      n_mo = 4'd9;
      n_st = 4'd5;
      n_so = 4'd9;
    end
  end

  // Partial seconds are dropped whenever counting is paused or done.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      ps <= '0;
    end else if (!en || timer_done || last) begin
      ps <= '0;
    end else begin
      ps <= ps + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      tick <= 1'b0;
    end else begin
      tick <= go;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
      min_tens <= 4'd0;
    end else if (go) begin
      sec_ones <= n_so;
      sec_tens <= n_st;
      min_ones <= n_mo;
      min_tens <= n_mt;
    end else if (load) begin
      min_tens <= min_ones;
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= key_data;
    end
  end

endmodule

// File: tb/tb_mmss_countdown.sv
// Randomized + directed scoreboard bench for mmss_countdown.
// Reference model works on integer minutes/seconds, not on BCD digit logic.
module tb_mmss_countdown;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       en = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_data = 4'd0;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       timer_done;
  logic       tick;

  mmss_countdown #(.CLK_PER_SEC(P)) dut (
    .clk        (clk),
    .clearn     (clearn),
    .en         (en),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .timer_done (timer_done),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: displayed minutes (0-99), displayed seconds (0-99)
  int mm = 0;
  int ss = 0;
  int cnt = 0;
  bit mtick = 0;

  typedef struct {
    string      nm;
    logic [17:0] exp;
  } item_t;
  item_t q[$];

  function automatic logic [17:0] outv();
    return {min_tens, min_ones, sec_tens, sec_ones, timer_done, tick};
  endfunction

  function automatic logic [17:0] modelv();
    logic [3:0] a, b, c, d;
    a = 4'(mm / 10);
    b = 4'(mm % 10);
    c = 4'(ss / 10);
    d = 4'(ss % 10);
    return {a, b, c, d, (mm == 0 && ss == 0), mtick};
  endfunction

  function automatic void chk(string nm, logic [17:0] act, logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    mm = 0;
    ss = 0;
    cnt = 0;
    mtick = 0;
  endfunction

  function automatic void model_edge(bit e, bit kv, int k);
    bit done;
    int v;
    done = (mm == 0 && ss == 0);
    mtick = 0;
    if (!e) begin
      cnt = 0;
      if (kv && k <= 9) begin
        v = ((mm * 100 + ss) * 10 + k) % 10000;
        mm = v / 100;
        ss = v % 100;
      end
    end else if (done) begin
      cnt = 0;
    end else if (cnt == P - 1) begin
      cnt = 0;
      mtick = 1;
      if (ss > 0) ss--;
      else begin
        mm--;
        ss = 59;
      end
    end else begin
      cnt++;
    end
  endfunction

  // monitor: one expected snapshot per clock edge
  always @(negedge clk) begin
    item_t it;
    if (q.size() > 0) begin
      it = q.pop_front();
      chk(it.nm, outv(), it.exp);
    end
  end

  // all tasks start and end just after a falling edge
  task automatic step(string nm, bit e, bit kv, int k);
    en = e;
    key_valid = kv;
    key_data = 4'(k);
    @(posedge clk);
    model_edge(e, kv, k);
    q.push_back('{nm, modelv()});
    @(negedge clk);
  endtask

  task automatic run(string nm, int n, bit e);
    for (int i = 0; i < n; i++) step(nm, e, 1'b0, 0);
  endtask

  task automatic key(string nm, int k);
    step(nm, 1'b0, 1'b1, k);
  endtask

  task automatic clear(string nm);
    #2 clearn = 1'b0;
    model_reset();
    #1 chk({nm, "_async"}, outv(), modelv());
    @(posedge clk);
    model_reset();
    q.push_back('{nm, modelv()});
    @(negedge clk);
    clearn = 1'b1;
  endtask

  initial begin
    int k;
    bit e;
    #1 chk("por", outv(), 18'h2);
    @(negedge clk);
    clearn = 1'b1;

    key("k1", 1);
    key("k2", 2);
    key("k3", 3);
    key("k0", 0);
    chk("entry_1230", outv(), {4'd1, 4'd2, 4'd3, 4'd0, 1'b0, 1'b0});
    key("kA", 10);
    key("kF", 15);
    run("idle", 2, 1'b0);

    clear("clr1");
    key("k5", 5);
    step("lock_en", 1'b1, 1'b0, 0);
    step("lock_k7", 1'b1, 1'b1, 7);
    chk("lockout", outv(), {4'd0, 4'd0, 4'd0, 4'd5, 1'b0, 1'b0});

    clear("clr2");
    key("k3b", 3);
    run("cd", 12 + 20, 1'b1);

    clear("clr3");
    key("k1c", 1);
    key("k0c", 0);
    key("k0d", 0);
    key("k0e", 0);
    run("borrow_min", P + 1, 1'b1);
    clear("clr4");
    key("k9", 9);
    key("k0f", 0);
    run("borrow_sec", P + 1, 1'b1);

    clear("clr5");
    key("k2p", 2);
    run("pause_on", 3, 1'b1);
    run("pause_off", 5, 1'b0);
    run("resume", P + 1, 1'b1);

    clear("clr6");
    key("k1m", 1);
    key("k0m", 0);
    key("k0n", 0);
    run("mid", 6, 1'b1);
    clear("mid_rst");
    run("after_rst", 3 * P, 1'b1);

    // max value and random traffic
    for (int i = 0; i < 4; i++) key("k9s", 9);
    run("max", 3 * P, 1'b1);
    for (int r = 0; r < 25; r++) begin
      e = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if ($urandom_range(0, 3) == 0) e = ~e;
        k = $urandom_range(0, 15);
        step("rnd", e, $urandom_range(0, 1) == 1, k);
      end
      if ($urandom_range(0, 9) == 0) clear("rnd_clr");
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmss_countdown.md
Name: mmss_countdown

Overview:
- Cooking-time register and countdown for the microwave controller. It sits directly upstream of the magnetron control latch.
- Keypad digits shift into a 4-digit BCD mm:ss display register while the magnetron is off.
- While the magnetron is on (en = latch Q), the register decrements once per second.
- timer_done is driven straight into the latch's timer_done input to switch the magnetron off at 00:00.

Parameters:
- CLK_PER_SEC, 1000000, clk cycles per one-second tick; must be >= 2. Benches override with 4.
- PS_W, $clog2(CLK_PER_SEC), prescaler counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge.
- clearn  input  1  asynchronous active-low reset/clear; same net as the front-panel clear button.
- en  input  1  count enable, driven by the control latch Q (1 = magnetron on).
- key_valid  input  1  one-cycle strobe: key_data holds a pressed digit.
- key_data  input  4  BCD digit 0-9 from the keypad encoder.
- sec_ones  output  4  BCD seconds units.
- sec_tens  output  4  BCD seconds tens.
- min_ones  output  4  BCD minutes units.
- min_tens  output  4  BCD minutes tens.
- timer_done  output  1  high whenever all four digits are 0.
- tick  output  1  one-cycle pulse in the cycle the display decrements.

Behaviour:
- Reset:
  - clearn low asynchronously sets all digits to 0, prescaler to 0, tick to 0.
  - timer_done therefore reads 1 during and after reset.
  - Reset mid-count aborts the count immediately; no further tick occurs.
- timer_done is combinational from the digit registers: (all digits == 0). It has no latency beyond the digit update.
- Digit entry (en = 0 only):
  - On a clk edge with key_valid = 1 and key_data <= 9, the digits shift left: min_tens <= min_ones, min_ones <= sec_tens, sec_tens <= sec_ones, sec_ones <= key_data.
  - The old min_tens is discarded.
  - key_data > 9 is ignored and no shift occurs.
  - sec_tens may legally hold 6-9 after entry (e.g. 00:99 = 99 s).
- Entry lockout: key_valid with en = 1 is ignored. en has priority in the same cycle.
- Prescaler:
  - Resets to 0 on any edge where en = 0 or timer_done = 1.
  - Otherwise counts 0 .. CLK_PER_SEC-1 and wraps.
  - Pausing (en low) discards the partial second.
- Decrement:
  - Occurs on the edge where en = 1, timer_done = 0 and prescaler == CLK_PER_SEC-1. tick is registered high for the cycle following that edge.
  - The first decrement therefore lands on the CLK_PER_SEC-th edge with en high.
- Borrow rules, in order:
  - sec_ones != 0: sec_ones - 1.
  - Else if sec_tens != 0: sec_tens - 1, sec_ones = 9.
  - Else if min_ones != 0: min_ones - 1, sec = 59.
  - Else: min_tens - 1, min_ones = 9, sec = 59.
- Terminal value:
  - On reaching 00:00, timer_done rises in the same cycle as the digit update. No decrement occurs below 00:00 (no wrap to 99:59).
  - Counting stays frozen while done, even if en stays high.
- Start at 00:00: en high produces no ticks. The downstream latch refuses to start because timer_done = 1.
- Max value 99:99 counts via borrows to 99:98 .. 99:90, 99:89, ...; no illegal BCD is ever produced.

Test Plan:
- Reset and digit entry:
  - clearn low mid-stream -> all digits 0, timer_done = 1, tick = 0.
  - Keys 1,2,3,0 with en = 0 -> 12:30, timer_done = 0.
  - key_data = 4'hA -> no change.
- Entry lockout: set 00:05, en = 1, then key_valid with key 7 -> digits stay 00:05.
- Countdown to zero (CLK_PER_SEC = 4): load 00:03, hold en = 1.
  - Ticks after 4, 8 and 12 edges -> 00:02, 00:01, 00:00.
  - timer_done = 1 at the 12th edge.
  - No further ticks over 20 more edges.
- Borrow chain: load 10:00, run one second -> 09:59. Load 00:90 (after clear), run one second -> 00:89.
- Pause/resume: load 00:02, en = 1 for 3 edges, en = 0 for 5, en = 1 again -> first tick 4 edges after re-enable (partial second discarded), value 00:01.
- Reset mid-count: en = 1 with 01:00, pulse clearn low between edges -> outputs 00:00 asynchronously, timer_done = 1 immediately, and no tick while en stays high.
